i2s_capture_rpi: RTL and testbench

I2S_CAPTURE_RPI -- requirements
Module: i2s_capture_rpi

---
 rtl/i2s_capture_rpi.sv | 277 +++++++++++++++++++++++++++
 tb/tb_i2s_capture_rpi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_rpi.sv
// I2S stereo capture into a small frame FIFO, drained by a Raspberry Pi over a
// clocked serial read (enable + clock, MSB first, data sampled on rpi_clk rising).
module i2s_capture_rpi #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i2s_bclk,
  input  logic                          i2s_lrclk,
  input  logic                          i2s_sdin,
  input  logic                          rpi_clk,
  input  logic                          rpi_enable,
  output logic                          rpi_serial,
  output logic                          rpi_interrupt,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FRAME_W = 2 * WORD_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int CW      = $clog2(WORD_W + 1);
  localparam int RCW     = $clog2(FRAME_W + 1);
  localparam logic [WORD_W-1:0] MSB_ONE = {1'b1, {(WORD_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers plus one history flop for the edge-detected inputs.
  // ---------------------------------------------------------------------------
  logic [4:0] async_in;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic       bclk_d;
  logic       rclk_d;
  logic       en_d;

  assign async_in = {rpi_enable, rpi_clk, i2s_sdin, i2s_lrclk, i2s_bclk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      bclk_d <= 1'b0;
      rclk_d <= 1'b0;
      en_d   <= 1'b0;
    end else begin
      sync1  <= async_in;
      sync2  <= sync1;
      bclk_d <= sync2[0];
      rclk_d <= sync2[3];
      en_d   <= sync2[4];
    end
  end

  logic bclk_s;
  logic lr_s;
  logic sdin_s;
  logic rclk_s;
  logic en_s;
  logic bclk_rise;
  logic rclk_fall;
  logic en_rise;
  logic en_fall;

  assign bclk_s    = sync2[0];
  assign lr_s      = sync2[1];
  assign sdin_s    = sync2[2];
  assign rclk_s    = sync2[3];
  assign en_s      = sync2[4];
  assign bclk_rise = bclk_s & ~bclk_d;
  assign rclk_fall = ~rclk_s & rclk_d;
  assign en_rise   = en_s & ~en_d;
  assign en_fall   = ~en_s & en_d;

  // ---------------------------------------------------------------------------
  // Capture FSM. The bclk edge that reveals an lrclk change still carries the
  // LSB of the slot that is ending, so the word is finalised with that bit.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    CAP_SYNC  = 2'd0,
    CAP_LEFT  = 2'd1,
    CAP_RIGHT = 2'd2
  } cap_state_t;

  cap_state_t          cap_state;
  logic                lr_prev;
  logic [CW-1:0]       bit_cnt;
  logic [CW-1:0]       bit_cnt_next;
  logic [WORD_W-1:0]   word_sh;
  logic [WORD_W-1:0]   word_next;
  logic [WORD_W-1:0]   left_word;
  logic                push_req;
  logic [FRAME_W-1:0]  push_frame;
  logic                lr_change;

  assign lr_change = lr_s ^ lr_prev;

  // Bits past WORD_W shift the mask out to zero; unfilled LSBs stay cleared.
  always_comb begin
    word_next    = word_sh | (sdin_s ? (MSB_ONE >> bit_cnt) : '0);
    bit_cnt_next = (bit_cnt < CW'(WORD_W)) ? bit_cnt + 1'b1 : bit_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state  <= CAP_SYNC;
      lr_prev    <= 1'b0;
      bit_cnt    <= '0;
      word_sh    <= '0;
      left_word  <= '0;
      push_req   <= 1'b0;
      push_frame <= '0;
    end else begin
      push_req <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lr_s;
        case (cap_state)
          CAP_SYNC: begin
            if (lr_change && !lr_s) begin
              cap_state <= CAP_LEFT;
              bit_cnt   <= '0;
              word_sh   <= '0;
            end
          end
          CAP_LEFT: begin
            if (lr_change) begin
              left_word <= word_next;
              cap_state <= CAP_RIGHT;
              bit_cnt   <= '0;
              word_sh   <= '0;
            end else begin
              word_sh <= word_next;
              bit_cnt <= bit_cnt_next;
            end
          end
          CAP_RIGHT: begin
            if (lr_change) begin
              push_frame <= {left_word, word_next};
              push_req   <= 1'b1;
              cap_state  <= CAP_LEFT;
              bit_cnt    <= '0;
              word_sh    <= '0;
            end else begin
              word_sh <= word_next;
              bit_cnt <= bit_cnt_next;
            end
          end
          default: cap_state <= CAP_SYNC;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FIFO. A push into a full FIFO is still accepted when the head is
  // popped in the same cycle, since the slot it overwrites is being released.
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               do_push;
  logic               do_pop;
  logic [FRAME_W-1:0] head;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_LOAD  = 2'd1,
    RD_SHIFT = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

  rd_state_t          rd_state;
  logic [FRAME_W-1:0] out_sh;
  logic [RCW-1:0]     rd_cnt;
  logic               rd_had_data;

  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];
  assign do_pop     = (rd_state == RD_DONE) && rd_had_data && !fifo_empty;
  assign do_push    = push_req && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_frame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (do_pop && !do_push) begin
        fifo_level <= fifo_level - 1'b1;
      end
      if (push_req && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. The head is only popped after a complete transfer, so an aborted
  // read leaves the frame in place to be re-sent.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state    <= RD_IDLE;
      out_sh      <= '0;
      rd_cnt      <= '0;
      rd_had_data <= 1'b0;
      rpi_serial  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          rpi_serial  <= 1'b0;
          rd_had_data <= 1'b0;
          if (en_rise) begin
            rd_state <= RD_LOAD;
          end
        end
        RD_LOAD: begin
          if (en_fall) begin
            rd_state   <= RD_IDLE;
            rpi_serial <= 1'b0;
          end else begin
            out_sh      <= fifo_empty ? '0 : head;
            rpi_serial  <= fifo_empty ? 1'b0 : head[FRAME_W-1];
            rd_had_data <= !fifo_empty;
            rd_cnt      <= '0;
            rd_state    <= RD_SHIFT;
          end
        end
        RD_SHIFT: begin
          if (en_fall) begin
            rd_state    <= RD_IDLE;
            rpi_serial  <= 1'b0;
            rd_had_data <= 1'b0;
          end else if (rclk_fall) begin
            out_sh <= {out_sh[FRAME_W-2:0], 1'b0};
            if (rd_cnt == RCW'(FRAME_W - 1)) begin
              rd_state   <= RD_DONE;
              rpi_serial <= 1'b0;
            end else begin
              rd_cnt     <= rd_cnt + 1'b1;
              rpi_serial <= out_sh[FRAME_W-2];
            end
          end
        end
        RD_DONE: begin
          rpi_serial  <= 1'b0;
          rd_had_data <= 1'b0;
          if (!en_s) begin
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign rpi_interrupt = !fifo_empty && (rd_state == RD_IDLE);

endmodule

// File: tb/tb_i2s_capture_rpi.sv
// Bench for i2s_capture_rpi: drives I2S frames and RPi reads, checks against a
// queue-based frame model plus hand-computed literal values.
module tb_i2s_capture_rpi;

  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_W    = 2 * WORD_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i2s_bclk = 1'b0;
  logic       i2s_lrclk = 1'b1;
  logic       i2s_sdin = 1'b0;
  logic       rpi_clk = 1'b0;
  logic       rpi_enable = 1'b0;
  logic       rpi_serial;
  logic       rpi_interrupt;
  logic       overflow;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  i2s_capture_rpi #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdin      (i2s_sdin),
    .rpi_clk       (rpi_clk),
    .rpi_enable    (rpi_enable),
    .rpi_serial    (rpi_serial),
    .rpi_interrupt (rpi_interrupt),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  // ---------------- scoreboard / model ----------------
  int                 n_checks = 0;
  int                 n_fail = 0;
  logic [FRAME_W-1:0] exp_q[$];
  logic               exp_ovf = 1'b0;
  logic               settled = 1'b0;
  logic               pending_bit = 1'b0;
  logic               lead_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word the DUT must keep from an nbits-wide slot: top WORD_W bits, zero padded.
  function automatic logic [WORD_W-1:0] slot_word(input logic [31:0] w, input int nbits);
    logic [31:0] t;
    if (nbits >= WORD_W) t = w >> (nbits - WORD_W);
    else                 t = w << (WORD_W - nbits);
    return t[WORD_W-1:0];
  endfunction

  task automatic model_push(input logic [FRAME_W-1:0] f);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(f);
    else exp_ovf = 1'b1;
  endtask

  always @(negedge clk) begin
    if (settled) begin
      check("fifo_level", 32'(fifo_level), exp_q.size());
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("rpi_interrupt", 32'(rpi_interrupt), 32'(exp_q.size() != 0));
      check("rpi_serial_idle", 32'(rpi_serial), 32'd0);
    end
  end

  // ---------------- I2S driver ----------------
  task automatic i2s_cycle(input logic lr, input logic d);
    i2s_lrclk = lr;
    i2s_sdin  = d;
    repeat (4) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (4) @(negedge clk);
    i2s_bclk = 1'b0;
  endtask

  // Cycle 0 of each slot carries the previous slot's LSB (one-bit delay).
  task automatic send_slot(input logic lr, input logic [31:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      if (k == 0) begin
        if (lead_done) lead_done = 1'b0;
        else i2s_cycle(lr, pending_bit);
      end else begin
        i2s_cycle(lr, w[nbits-k]);
      end
    end
    pending_bit = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
    send_slot(1'b0, l, nbits);
    send_slot(1'b1, r, nbits);
    model_push({slot_word(l, nbits), slot_word(r, nbits)});
  endtask

  task automatic flush();
    i2s_cycle(1'b0, pending_bit);
    lead_done = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic preamble();
    lead_done = 1'b0;
    i2s_cycle(1'b1, 1'b0);
    i2s_cycle(1'b1, 1'b0);
  endtask

  // ---------------- RPi driver ----------------
  task automatic rpi_read(input int nbits, output logic [31:0] got);
    got = '0;
    rpi_enable = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      got = {got[30:0], rpi_serial};
      rpi_clk = 1'b1;
      repeat (6) @(negedge clk);
      rpi_clk = 1'b0;
      repeat (6) @(negedge clk);
    end
    rpi_enable = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic read_check(input string name, output logic [31:0] got);
    logic [31:0] exp;
    settled = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
    rpi_read(32, got);
    check(name, got, exp);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    settled = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] got;
  logic [31:0] exp_word;

  initial begin
    repeat (4) @(negedge clk);
    check("reset_fifo_level", 32'(fifo_level), 32'd0);
    check("reset_interrupt", 32'(rpi_interrupt), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_serial", 32'(rpi_serial), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    settled = 1'b1;

    // Two frames, then two full reads.
    settled = 1'b0;
    preamble();
    send_frame(32'hA5C3, 32'h1234, 16);
    send_frame(32'hFFFF, 32'h0001, 16);
    flush();
    settled = 1'b1;
    repeat (2) @(negedge clk);
    check("two_frames_level", 32'(fifo_level), 32'd2);
    check("two_frames_irq", 32'(rpi_interrupt), 32'd1);
    read_check("read_a", got);
    check("read_a_literal", got, 32'hA5C31234);
    read_check("read_b", got);
    check("read_b_literal", got, 32'hFFFF0001);
    check("drained_level", 32'(fifo_level), 32'd0);

    // Aborted read after 10 bits re-sends the same frame.
    settled = 1'b0;
    send_frame(32'h0F0F, 32'h8001, 16);
    flush();
    exp_word = exp_q[0];
    rpi_read(10, got);
    check("abort_bits", got, exp_word >> 22);
    check("abort_bits_literal", got, 32'h03C);
    settled = 1'b1;
    repeat (2) @(negedge clk);
    read_check("read_after_abort", got);
    check("read_after_abort_literal", got, 32'h0F0F8001);

    // Six frames with no reads: four kept, overflow sticky.
    settled = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send_frame(32'h1000 + i, 32'h2000 + i, 16);
    end
    flush();
    settled = 1'b1;
    repeat (2) @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_overflow", 32'(overflow), 32'd1);
    read_check("ovf_read_1", got);
    check("ovf_read_1_literal", got, 32'h10012001);
    read_check("ovf_read_2", got);
    read_check("ovf_read_3", got);
    read_check("ovf_read_4", got);
    check("ovf_read_4_literal", got, 32'h10042004);

    // Read with FIFO empty.
    read_check("empty_read", got);
    check("empty_read_literal", got, 32'h0);
    check("empty_overflow_kept", 32'(overflow), 32'd1);

    // Long slots truncate, short slots zero-pad.
    settled = 1'b0;
    send_frame(32'hABCDEF, 32'hABCDEF, 24);
    send_frame(32'hABC, 32'hABC, 12);
    flush();
    settled = 1'b1;
    read_check("long_slot", got);
    check("long_slot_literal", got, 32'hABCDABCD);
    read_check("short_slot", got);
    check("short_slot_literal", got, 32'hABC0ABC0);

    // Reset mid right slot, one frame left buffered before it.
    settled = 1'b0;
    send_frame(32'h7777, 32'h6666, 16);
    send_slot(1'b0, 32'h1111, 16);
    i2s_cycle(1'b1, pending_bit);
    for (int k = 1; k < 8; k++) i2s_cycle(1'b1, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    settled = 1'b1;
    repeat (4) @(negedge clk);
    check("midreset_level", 32'(fifo_level), 32'd0);
    check("midreset_overflow", 32'(overflow), 32'd0);
    settled = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    preamble();
    send_frame(32'h5A5A, 32'hC3C3, 16);
    flush();
    settled = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_level", 32'(fifo_level), 32'd1);
    read_check("post_reset_read", got);
    check("post_reset_literal", got, 32'h5A5AC3C3);

    settled = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
